mac_lane_array: RTL and testbench
=================================

Name: mac_lane_array

Overview:
- Parametrised successor to the fixed four-lane MAC quad.
- Holds NUM_LANES weight-stationary MAC lanes. Each lane keeps two double-buffered weight planes: a shadow copy, which is loaded systolically, and an active copy, which is committed on set_weight.
- Adds activation valid qualification, a per-issue plane select, a fixed 2-cycle pipeline, and optional saturating accumulation.
- Sits in the systolic array between the activation skew buffers and the partial-sum chain.

Parameters:
- NUM_LANES, 4, number of independent MAC lanes (1..16).
- QUNATIZED_MANTISSA_WIDTH, 7, unsigned activation mantissa width M.
- WEIGHT_WIDTH, 8, two's-complement weight width W.
- MAC_ACC_WIDTH, 48, two's-complement accumulator width A (A > M+W+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prepare_weight  in  1  capture i_load_weight_data_* into shadow registers.
- set_weight_i  in  1  commit shadow to active weights.
- weight_sel_i  in  1  plane used by the current issue (0 = plane 0, 1 = plane 1).
- sat_en_i  in  1  1 = saturate the accumulation, 0 = wrap modulo 2^A.
- mac_valid_i  in  1  activations and partial sums valid this cycle.
- mac_mantissa_activation_i  in  NUM_LANES*M  lane k at bits [k*M +: M].
- mac_acc_i  in  NUM_LANES*A  incoming partial sums, lane k at bits [k*A +: A].
- mac_valid_o  out  1  mac_acc_o valid.
- mac_acc_o  out  NUM_LANES*A  outgoing partial sums.
- mac_sat_o  out  NUM_LANES  per-lane flag: saturation occurred on this output.
- i_load_weight_data_0  in  NUM_LANES*W  plane-0 weights from upstream.
- i_load_weight_data_1  in  NUM_LANES*W  plane-1 weights from upstream.
- o_load_weight_data_0  out  NUM_LANES*W  plane-0 shadow forwarded downstream.
- o_load_weight_data_1  out  NUM_LANES*W  plane-1 shadow forwarded downstream.

Behaviour:
- Reset (async assert, sync-released by top): shadow and active weights = 0; pipeline registers = 0; mac_valid_o = 0; mac_acc_o = 0; mac_sat_o = 0; o_load_weight_data_* = 0.
- Weight load:
  - On a clk edge with prepare_weight=1, shadow[k][p] <= i_load_weight_data_p[k] for every lane k and plane p.
  - o_load_weight_data_p is the registered shadow value, giving a 1-cycle hop per array column.
  - With prepare_weight=0 the shadow holds.
- Weight commit:
  - On a clk edge with set_weight_i=1, active[k][p] <= shadow[k][p] (the pre-edge value).
  - prepare_weight and set_weight_i together: active receives the OLD shadow; shadow receives the new data.
- Stage 1 (issue edge, mac_valid_i=1):
  - Register act[k], weight w = active[k][weight_sel_i], acc_i[k], sat_en_i.
  - The weight is sampled at issue. A set_weight_i in the same or a later cycle never affects in-flight operations.
  - Stage 1 captures the pre-edge active value when set_weight_i coincides with issue.
- Stage 2 (next edge):
  - prod = zero-extend(act) × sign(w), as a signed (M+W+1)-bit value, sign-extended to A.
  - sum = acc + prod, computed at A+1 bits.
  - Wrap mode: mac_acc_o = sum[A-1:0]; mac_sat_o = 0.
  - Saturate mode, on overflow: output = +2^(A-1)-1 or -2^(A-1), and mac_sat_o[k] = 1. Overflow means the two's-complement sign bits of the operands agree and the result sign differs.
- Latency and valid:
  - mac_valid_o = mac_valid_i delayed exactly 2 cycles. Back-to-back issues give back-to-back outputs; throughput is 1 per cycle per lane.
  - Cycles with mac_valid_i=0 do not update the stage-1 data registers. Outputs hold their last values, and mac_valid_o drops 2 cycles later.
- Lanes are fully independent; all lanes share the control signals.
- Reset mid-operation: all in-flight results are discarded; mac_valid_o = 0 immediately (asynchronously).
- act = 0 or w = 0 passes acc_i through unchanged after 2 cycles.

Test Plan:
- Load and forward:
  - Stimulus: reset; prepare_weight=1 with plane-0 lane0 = 8'h05, plane-1 lane0 = 8'hFD; next cycle set_weight_i.
  - Required: o_load_weight_data_0[7:0] = 05 one cycle after prepare; active weights updated after the set edge.
- Basic MAC:
  - Stimulus: weight_sel_i=0, act=3, acc_i=100, mac_valid_i for 1 cycle.
  - Required: 2 cycles later mac_valid_o=1 and lane0 acc_o = 115. With weight_sel_i=1, act=7: acc_o = 100 - 21 = 79.
- Coincident prepare/set during streaming:
  - Stimulus: 4 consecutive issues with set_weight_i and prepare_weight in the 2nd issue cycle.
  - Required: the first 2 results use the old weights, the last 2 use the old shadow; outputs are contiguous valid.
- Saturation:
  - Stimulus: A=48, acc_i = 2^47-10, w=+127, act=1.
  - Required: sat_en=1 gives acc_o = 2^47-1 and mac_sat_o=1; sat_en=0 gives the wrapped negative value and mac_sat_o=0. A negative case with acc_i = -2^47+5, w=-128, act=1 must give -2^47.
- Per-lane independence:
  - Stimulus: NUM_LANES=8, distinct act/weight per lane, including act=127 with w=-128.
  - Required: each lane equals its golden model; mac_valid_i gaps give mac_valid_o gaps with matching 2-cycle delay.
- Reset mid-pipe:
  - Stimulus: assert rst_n=0 one cycle after an issue.
  - Required: mac_valid_o=0, all outputs 0, weights 0; after release, a first issue with default weights returns acc_i unchanged.

Source files
------------

// File: rtl/mac_lane_array.sv
// mac_lane_array: NUM_LANES weight-stationary MAC lanes with double-buffered weight planes,
// a fixed 2-cycle issue-to-result pipeline and optional saturating accumulation.
module mac_lane_array #(
    parameter int NUM_LANES                = 4,
    parameter int QUNATIZED_MANTISSA_WIDTH = 7,
    parameter int WEIGHT_WIDTH             = 8,
    parameter int MAC_ACC_WIDTH            = 48
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         prepare_weight,
    input  logic                                         set_weight_i,
    input  logic                                         weight_sel_i,
    input  logic                                         sat_en_i,
    input  logic                                         mac_valid_i,
    input  logic [NUM_LANES*QUNATIZED_MANTISSA_WIDTH-1:0] mac_mantissa_activation_i,
    input  logic [NUM_LANES*MAC_ACC_WIDTH-1:0]            mac_acc_i,
    output logic                                         mac_valid_o,
    output logic [NUM_LANES*MAC_ACC_WIDTH-1:0]            mac_acc_o,
    output logic [NUM_LANES-1:0]                          mac_sat_o,
    input  logic [NUM_LANES*WEIGHT_WIDTH-1:0]             i_load_weight_data_0,
    input  logic [NUM_LANES*WEIGHT_WIDTH-1:0]             i_load_weight_data_1,
    output logic [NUM_LANES*WEIGHT_WIDTH-1:0]             o_load_weight_data_0,
    output logic [NUM_LANES*WEIGHT_WIDTH-1:0]             o_load_weight_data_1
);
    localparam int N = NUM_LANES;
    localparam int M = QUNATIZED_MANTISSA_WIDTH;
    localparam int W = WEIGHT_WIDTH;
    localparam int A = MAC_ACC_WIDTH;

    logic [N*W-1:0] active_0, active_1;
    logic [N*M-1:0] act_q;
    logic [N*W-1:0] w_q;
    logic [N*A-1:0] acc_q;
    logic           sat_q;
    logic           v1;
    logic [N*A-1:0] res;
    logic [N-1:0]   res_sat;

    // The shadow registers double as the forwarded copy for the next column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_load_weight_data_0 <= '0;
            o_load_weight_data_1 <= '0;
            active_0             <= '0;
            active_1             <= '0;
        end else begin
            if (prepare_weight) begin
                o_load_weight_data_0 <= i_load_weight_data_0;
                o_load_weight_data_1 <= i_load_weight_data_1;
            end
            if (set_weight_i) begin
                active_0 <= o_load_weight_data_0;
                active_1 <= o_load_weight_data_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            act_q <= '0;
            w_q   <= '0;
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            v1 <= mac_valid_i;
            if (mac_valid_i) begin
                act_q <= mac_mantissa_activation_i;
                w_q   <= weight_sel_i ? active_1 : active_0;
                acc_q <= mac_acc_i;
                sat_q <= sat_en_i;
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [M+W:0] prod;
        logic [A:0]   sum;
        logic         ovf;
        assign prod = $signed({{(W+1){1'b0}}, act_q[k*M +: M]})
                    * $signed({{(M+1){w_q[k*W+W-1]}}, w_q[k*W +: W]});
        assign sum  = {acc_q[k*A+A-1], acc_q[k*A +: A]} + {{(A-M-W){prod[M+W]}}, prod};
        // A+1-bit sum: the two top bits disagree exactly when the A-bit result overflowed.
        assign ovf  = sum[A] != sum[A-1];
        assign res_sat[k]     = sat_q && ovf;
        assign res[k*A +: A]  = res_sat[k] ? (sum[A] ? {1'b1, {(A-1){1'b0}}} : {1'b0, {(A-1){1'b1}}})
                                           : sum[A-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_valid_o <= 1'b0;
            mac_acc_o   <= '0;
            mac_sat_o   <= '0;
        end else begin
            mac_valid_o <= v1;
            if (v1) begin
                mac_acc_o <= res;
                mac_sat_o <= res_sat;
            end
        end
    end
endmodule

// File: tb/tb_mac_lane_array.sv
// tb_mac_lane_array: table-driven stimulus with a reference model feeding a scoreboard
// that is drained by a monitor checking value and issue-to-result latency.
module tb_mac_lane_array;
    localparam int N = 8;
    localparam int M = 7;
    localparam int W = 8;
    localparam int A = 48;

    logic           clk = 0;
    logic           rst_n;
    logic           prepare_weight, set_weight_i, weight_sel_i, sat_en_i, mac_valid_i;
    logic [N*M-1:0] act_bus;
    logic [N*A-1:0] acc_bus;
    logic           mac_valid_o;
    logic [N*A-1:0] mac_acc_o;
    logic [N-1:0]   mac_sat_o;
    logic [N*W-1:0] wd0, wd1, o_ld0, o_ld1;

    mac_lane_array #(
        .NUM_LANES(N), .QUNATIZED_MANTISSA_WIDTH(M), .WEIGHT_WIDTH(W), .MAC_ACC_WIDTH(A)
    ) dut (
        .clk(clk), .rst_n(rst_n), .prepare_weight(prepare_weight), .set_weight_i(set_weight_i),
        .weight_sel_i(weight_sel_i), .sat_en_i(sat_en_i), .mac_valid_i(mac_valid_i),
        .mac_mantissa_activation_i(act_bus), .mac_acc_i(acc_bus), .mac_valid_o(mac_valid_o),
        .mac_acc_o(mac_acc_o), .mac_sat_o(mac_sat_o),
        .i_load_weight_data_0(wd0), .i_load_weight_data_1(wd1),
        .o_load_weight_data_0(o_ld0), .o_load_weight_data_1(o_ld1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        prep, set, sel, sat, vld;
        logic [M-1:0] act;
        logic [A-1:0] acc;
        logic [W-1:0] w0, w1;
        logic [A-1:0] exp;
        logic         exps;
    } vec_t;

    typedef struct {
        logic [N*A-1:0] acc;
        logic [N-1:0]   sat;
        int             cyc;
    } sb_t;

    sb_t  q[$];
    vec_t tbl[20];
    int   checks = 0, errors = 0, cyc_cnt = 0;
    logic mon_en = 0;
    logic signed [W-1:0] sh_m[N][2], ac_m[N][2];

    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string nm, input logic [N*A-1:0] a, input logic [N*A-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic vec_t mk(input logic prep, set, sel, sat, vld, input logic [M-1:0] act,
                                input logic signed [A-1:0] acc, input logic [W-1:0] w0, w1,
                                input logic signed [A-1:0] exp, input logic exps);
        vec_t v;
        v.prep = prep; v.set = set; v.sel = sel; v.sat = sat; v.vld = vld; v.act = act;
        v.acc = acc; v.w0 = w0; v.w1 = w1; v.exp = exp; v.exps = exps;
        return v;
    endfunction

    function automatic void mdl(input logic [M-1:0] a, input logic signed [W-1:0] w,
                                input logic signed [A-1:0] acc, input logic s,
                                output logic [A-1:0] r, output logic f);
        longint mx, mn, sum;
        mx  = 64'sh7FFF_FFFF_FFFF;
        mn  = -mx - 1;
        sum = longint'(acc) + longint'(a) * longint'(w);
        f   = s && (sum > mx || sum < mn);
        r   = !f ? sum[A-1:0] : (sum > mx ? mx[A-1:0] : mn[A-1:0]);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++)
            for (int p = 0; p < 2; p++) begin
                sh_m[k][p] = '0;
                ac_m[k][p] = '0;
            end
    endtask

    // Drives one cycle; lane 0 comes from the vector, other lanes are random except lane N-1,
    // which always carries act=127 and extreme weights.
    task automatic cyc(input vec_t v);
        sb_t e;
        logic [31:0] r;
        prepare_weight = v.prep; set_weight_i = v.set; weight_sel_i = v.sel;
        sat_en_i = v.sat; mac_valid_i = v.vld;
        for (int k = 0; k < N; k++) begin
            r = $urandom;
            act_bus[k*M +: M] = k == 0 ? v.act : (k == N-1 ? 7'd127 : M'($urandom_range(127)));
            acc_bus[k*A +: A] = k == 0 ? v.acc : {{16{r[31]}}, r};
            wd0[k*W +: W] = k == 0 ? v.w0 : (k == N-1 ? 8'h80 : W'($urandom));
            wd1[k*W +: W] = k == 0 ? v.w1 : (k == N-1 ? 8'h7F : W'($urandom));
        end
        if (v.vld) begin
            for (int k = 0; k < N; k++) begin
                logic [A-1:0] ra;
                logic rf;
                mdl(act_bus[k*M +: M], ac_m[k][v.sel], acc_bus[k*A +: A], v.sat, ra, rf);
                e.acc[k*A +: A] = k == 0 ? v.exp : ra;
                e.sat[k]        = k == 0 ? v.exps : rf;
            end
            e.cyc = cyc_cnt + 2;
            q.push_back(e);
        end
        for (int k = 0; k < N; k++) begin
            if (v.set) begin
                ac_m[k][0] = sh_m[k][0];
                ac_m[k][1] = sh_m[k][1];
            end
            if (v.prep) begin
                sh_m[k][0] = wd0[k*W +: W];
                sh_m[k][1] = wd1[k*W +: W];
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mac_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    sb_t e;
                    e = q.pop_front();
                    chk("latency", cyc_cnt, e.cyc);
                    chk("acc", mac_acc_o, e.acc);
                    chk("sat", mac_sat_o, e.sat);
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc_cnt) begin
                chk("missing_valid", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 0;
        prepare_weight = 0; set_weight_i = 0; weight_sel_i = 0; sat_en_i = 0; mac_valid_i = 0;
        act_bus = '0; acc_bus = '0; wd0 = '0; wd1 = '0;
        clear_model();
        tbl[0]  = mk(0,0,0,0,1,   3, 100,                 0,0, 115,                   0);
        tbl[1]  = mk(0,0,1,0,1,   7, 100,                 0,0, 79,                    0);
        tbl[2]  = mk(0,0,0,0,1,   0, -5,                  0,0, -5,                    0);
        tbl[3]  = mk(0,0,0,0,0,   0, 0,                   0,0, 0,                     0);
        tbl[4]  = mk(0,0,1,0,1, 127, 0,                   0,0, -381,                  0);
        tbl[5]  = mk(0,0,0,0,0,   0, 0,                   0,0, 0,                     0);
        tbl[6]  = mk(1,0,0,0,0,   0, 0,       8'h7F,8'h80, 0,                     0);
        tbl[7]  = mk(0,1,0,0,0,   0, 0,                   0,0, 0,                     0);
        tbl[8]  = mk(0,0,0,1,1,   1, 48'h7FFF_FFFF_FFF6,  0,0, 48'h7FFF_FFFF_FFFF,    1);
        tbl[9]  = mk(0,0,0,0,1,   1, 48'h7FFF_FFFF_FFF6,  0,0, 48'h8000_0000_0075,    0);
        tbl[10] = mk(0,0,1,1,1,   1, 48'h8000_0000_0005,  0,0, 48'h8000_0000_0000,    1);
        tbl[11] = mk(0,0,1,0,1,   1, 48'h8000_0000_0005,  0,0, 48'h7FFF_FFFF_FF85,    0);
        tbl[12] = mk(0,0,0,1,1,   2, 1000,                0,0, 1254,                  0);
        tbl[13] = mk(1,0,0,0,0,   0, 0,       8'd10,8'hF6, 0,                     0);
        tbl[14] = mk(0,0,0,0,1,   2, 0,                   0,0, 254,                   0);
        tbl[15] = mk(1,1,0,0,1,   2, 0,       8'd20,8'hEC, 254,                   0);
        tbl[16] = mk(0,0,0,0,1,   2, 0,                   0,0, 20,                    0);
        tbl[17] = mk(0,0,1,0,1,   2, 0,                   0,0, -20,                   0);
        tbl[18] = mk(0,1,0,0,0,   0, 0,                   0,0, 0,                     0);
        tbl[19] = mk(0,0,0,0,1,   1, 5,                   0,0, 25,                    0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", mac_valid_o, 0);
        chk("rst_acc", mac_acc_o, 0);
        chk("rst_sat", mac_sat_o, 0);
        chk("rst_ld0", o_ld0, 0);
        chk("rst_ld1", o_ld1, 0);
        rst_n = 1;
        mon_en = 1;
        @(posedge clk);
        #1;

        cyc(mk(1,0,0,0,0, 0, 0, 8'h05, 8'hFD, 0, 0));
        chk("fwd_ld0_lane0", o_ld0[W-1:0], 8'h05);
        chk("fwd_ld1_lane0", o_ld1[W-1:0], 8'hFD);
        chk("fwd_ld0_lane7", o_ld0[N*W-1 -: W], 8'h80);
        cyc(mk(0,1,0,0,0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) cyc(tbl[i]);
        repeat (3) cyc(mk(0,0,0,0,0, 0, 0, 0, 0, 0, 0));

        // Reset one cycle after an issue, with a second result still in stage 1.
        cyc(mk(0,0,0,0,1, 4, 50, 0, 0, 130, 0));
        cyc(mk(0,0,0,0,1, 4, 60, 0, 0, 140, 0));
        mon_en = 0;
        chk("pre_rst_valid", mac_valid_o, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", mac_valid_o, 0);
        chk("mid_rst_acc", mac_acc_o, 0);
        chk("mid_rst_sat", mac_sat_o, 0);
        chk("mid_rst_ld0", o_ld0, 0);
        chk("mid_rst_ld1", o_ld1, 0);
        q.delete();
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1;
        mon_en = 1;
        cyc(mk(0,0,0,0,1, 9, 777, 0, 0, 777, 0));
        cyc(mk(0,0,1,1,1, 127, -3, 0, 0, -3, 0));
        repeat (4) cyc(mk(0,0,0,0,0, 0, 0, 0, 0, 0, 0));
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
